key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl_pkg.sv | 25 ++
 rtl/key_filter.sv | 48 ++++
 rtl/key_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_key_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: event and FSM types shared by the key controller.
// Optional feature macro: KEY_CTRL_REPEAT_EN (adds the auto-repeat state).
package key_ctrl_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_REPEAT  = 2'b01,
    EVT_RELEASE = 2'b10
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_OUT = 2'd2
`ifdef KEY_CTRL_REPEAT_EN
    ,
    ST_REPEAT   = 2'd3
`endif
  } state_e;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_filter.sv
// key_filter: one key channel, a two-flop synchroniser followed by a
// debounce filter that only changes level after DEB_CYCLES consecutive
// samples disagreeing with the current level.
module key_filter #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          syncMeta_q;
  logic          syncOut_q;
  logic          level_q;
  logic [CW-1:0] count_q;

  // Bring the asynchronous key level into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
    end else begin
      syncMeta_q <= raw_i;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      count_q <= '0;
    end else if (syncOut_q == level_q) begin
      count_q <= '0;
    end else if (count_q == CW'(DEB_CYCLES - 1)) begin
      level_q <= syncOut_q;
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/key_ctrl.sv
// key_ctrl: debounced multi-key controller producing PRESS / REPEAT /
// RELEASE events through a one-entry valid/ready output buffer.
// Optional feature macro: KEY_CTRL_REPEAT_EN enables the auto-repeat
// timer, the REPEAT state and the evt_drop pulse.
module key_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int DEB_CYCLES    = 4,
  parameter int HOLD_CYCLES   = 20,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_in,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_type,
  output logic                        evt_drop,
  output logic                        busy
);

  localparam int KW = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] level;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : gFilter
    key_filter #(.DEB_CYCLES(DEB_CYCLES)) uFilter (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (key_in[g]),
      .level_o(level[g])
    );
  end

  state_e    state_q, state_d;
  logic [KW-1:0] activeKey_q, activeKey_d;
  evt_type_e pendType_q, pendType_d;
  logic      evtValid_q;
  logic [KW-1:0] evtKey_q;
  evt_type_e evtType_q;

  logic      canLoad;
  logic      activeLevel;
  logic [KW-1:0] lowestKey;
  logic      push;
  evt_type_e pushType;
  logic      releaseReq;

`ifdef KEY_CTRL_REPEAT_EN
  localparam int TW = $clog2(maxOf(HOLD_CYCLES, REPEAT_CYCLES));
  logic [TW-1:0] timer_q, timer_d;
  logic          repeatReq;
  logic          drop_d;
  logic          evtDrop_q;
`else
  logic unusedCfg;
  assign unusedCfg = (HOLD_CYCLES != REPEAT_CYCLES);
`endif

  // Pick the lowest-numbered key whose debounced level is high.
  always_comb begin
    lowestKey = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (level[i]) lowestKey = KW'(i);
    end
  end

  assign canLoad     = !evtValid_q || evt_ready;
  assign activeLevel = level[activeKey_q];

  // Next-state logic: decide which event to enqueue and where to go.
  always_comb begin
    state_d     = state_q;
    activeKey_d = activeKey_q;
    pendType_d  = pendType_q;
    push        = 1'b0;
    pushType    = EVT_PRESS;
    releaseReq  = 1'b0;
`ifdef KEY_CTRL_REPEAT_EN
    timer_d     = timer_q;
    repeatReq   = 1'b0;
    drop_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef KEY_CTRL_REPEAT_EN
        timer_d = '0;
`endif
        if (|level) begin
          activeKey_d = lowestKey;
          if (canLoad) begin
            push     = 1'b1;
            pushType = EVT_PRESS;
            state_d  = ST_HOLD;
          end else begin
            pendType_d = EVT_PRESS;
            state_d    = ST_WAIT_OUT;
          end
        end
      end
      ST_HOLD: begin
        if (!activeLevel) begin
          releaseReq = 1'b1;
        end
`ifdef KEY_CTRL_REPEAT_EN
        else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          repeatReq = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
`ifdef KEY_CTRL_REPEAT_EN
      ST_REPEAT: begin
        if (!activeLevel) begin
          releaseReq = 1'b1;
        end else if (timer_q == TW'(REPEAT_CYCLES - 1)) begin
          repeatReq = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_WAIT_OUT: begin
`ifdef KEY_CTRL_REPEAT_EN
        timer_d = '0;
`endif
        if (canLoad) begin
          push     = 1'b1;
          pushType = pendType_q;
          state_d  = (pendType_q == EVT_RELEASE) ? ST_IDLE : ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (releaseReq) begin
      if (canLoad) begin
        push     = 1'b1;
        pushType = EVT_RELEASE;
        state_d  = ST_IDLE;
      end else begin
        pendType_d = EVT_RELEASE;
        state_d    = ST_WAIT_OUT;
      end
    end

`ifdef KEY_CTRL_REPEAT_EN
    if (repeatReq) begin
      timer_d = '0;
      state_d = ST_REPEAT;
      if (canLoad) begin
        push     = 1'b1;
        pushType = EVT_REPEAT;
      end else begin
        drop_d = 1'b1;
      end
    end
`endif
  end

  // FSM state, latched key and pending event type.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      activeKey_q <= '0;
      pendType_q  <= EVT_PRESS;
    end else begin
      state_q     <= state_d;
      activeKey_q <= activeKey_d;
      pendType_q  <= pendType_d;
    end
  end

  // One-entry output buffer; a new event may load while the old one drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evtValid_q <= 1'b0;
      evtKey_q   <= '0;
      evtType_q  <= EVT_PRESS;
    end else if (push) begin
      evtValid_q <= 1'b1;
      evtKey_q   <= activeKey_d;
      evtType_q  <= pushType;
    end else if (evt_ready) begin
      evtValid_q <= 1'b0;
    end
  end

`ifdef KEY_CTRL_REPEAT_EN
  // Repeat timer and the one-cycle drop indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      evtDrop_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      evtDrop_q <= drop_d;
    end
  end

  assign evt_drop = evtDrop_q;
`else
  assign evt_drop = 1'b0;
`endif

  assign evt_valid = evtValid_q;
  assign evt_key   = evtKey_q;
  assign evt_type  = evtType_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed scoreboard bench for key_ctrl with default
// parameters. Expected events are queued by the stimulus process and
// compared by an independent monitor when the DUT presents them.
module tb_key_ctrl;

  localparam int NK        = 4;
  localparam int T_PRESS   = 0;
  localparam int T_REPEAT  = 1;
  localparam int T_RELEASE = 2;
`ifdef KEY_CTRL_REPEAT_EN
  localparam int BP_DROPS  = 5;
  localparam int RST_DROPS = 2;
`else
  localparam int BP_DROPS  = 0;
  localparam int RST_DROPS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_key;
  logic [1:0]    evt_type;
  logic          evt_drop;
  logic          busy;

  typedef struct {
    int key;
    int typ;
    int atEdge;
  } exp_t;

  exp_t sbQ[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   edgeCount  = 0;
  int   dropCount  = 0;
  logic prevHeld   = 1'b0;
  int   heldKey    = 0;
  int   heldType   = 0;

  key_ctrl #(
    .NUM_KEYS     (4),
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .evt_drop (evt_drop),
    .busy     (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp expected events.
  always @(posedge clk) edgeCount = edgeCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keys, input logic ready);
    key_in    = keys;
    evt_ready = ready;
  endtask

  task automatic expectEvent(input int key, input int typ, input int atEdge);
    exp_t e;
    e.key    = key;
    e.typ    = typ;
    e.atEdge = atEdge;
    sbQ.push_back(e);
  endtask

  task automatic waitUntil(input int target);
    while (edgeCount < target) @(negedge clk);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, int'(evt_valid), 0);
    checkOutput({tag, "_key"},   int'(evt_key),   0);
    checkOutput({tag, "_type"},  int'(evt_type),  T_PRESS);
    checkOutput({tag, "_drop"},  int'(evt_drop),  0);
    checkOutput({tag, "_busy"},  int'(busy),      0);
  endtask

  // Monitor: samples just before each rising edge, pops the scoreboard on
  // each newly presented event and checks held events stay stable.
  always begin
    @(negedge clk);
    #4;
    if (rst) begin
      prevHeld = 1'b0;
    end else begin
      if (evt_drop) dropCount++;
      if (evt_valid) begin
        if (!prevHeld) begin
          if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_event: got key %0d type %0d, expected none (edge %0d)",
                     evt_key, evt_type, edgeCount);
            heldKey  = int'(evt_key);
            heldType = int'(evt_type);
          end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("evt_key",  int'(evt_key),  e.key);
            checkOutput("evt_type", int'(evt_type), e.typ);
            checkOutput("evt_edge", edgeCount,      e.atEdge);
            heldKey  = e.key;
            heldType = e.typ;
          end
        end else begin
          checkOutput("stable_key",  int'(evt_key),  heldKey);
          checkOutput("stable_type", int'(evt_type), heldType);
        end
      end
      prevHeld = evt_valid && !evt_ready;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int   t0;
    int   t1;
    int   t2;
    int   d0;
    logic sawBusy;
    logic sawValid;

    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Glitch shorter than the debounce window.
    t0 = edgeCount;
    applyStimulus(4'b0010, 1'b1);
    waitUntil(t0 + 3);
    applyStimulus(4'b0000, 1'b1);
    sawBusy  = 1'b0;
    sawValid = 1'b0;
    repeat (15) begin
      @(negedge clk);
      sawBusy  = sawBusy | busy;
      sawValid = sawValid | evt_valid;
    end
    checkOutput("glitch_busy",  int'(sawBusy),  0);
    checkOutput("glitch_valid", int'(sawValid), 0);

    // Short tap on key 2.
    t0 = edgeCount;
    applyStimulus(4'b0100, 1'b1);
    expectEvent(2, T_PRESS, t0 + 7);
    waitUntil(t0 + 12);
    applyStimulus(4'b0000, 1'b1);
    expectEvent(2, T_RELEASE, t0 + 19);
    waitUntil(t0 + 35);

    // Long hold on key 0; release coincides with a repeat slot.
    d0 = dropCount;
    t0 = edgeCount;
    applyStimulus(4'b0001, 1'b1);
    expectEvent(0, T_PRESS, t0 + 7);
`ifdef KEY_CTRL_REPEAT_EN
    for (int k = 0; k < 5; k++) expectEvent(0, T_REPEAT, t0 + 27 + 8 * k);
`endif
    waitUntil(t0 + 30);
    checkOutput("hold_busy", int'(busy), 1);
    waitUntil(t0 + 60);
    applyStimulus(4'b0000, 1'b1);
    expectEvent(0, T_RELEASE, t0 + 67);
    waitUntil(t0 + 75);
    checkOutput("hold_idle",  int'(busy), 0);
    checkOutput("hold_drops", dropCount - d0, 0);

    // Simultaneous keys 0 and 3.
    t0 = edgeCount;
    applyStimulus(4'b1001, 1'b1);
    expectEvent(0, T_PRESS, t0 + 7);
    waitUntil(t0 + 12);
    t1 = edgeCount;
    applyStimulus(4'b1000, 1'b1);
    expectEvent(0, T_RELEASE, t1 + 7);
    expectEvent(3, T_PRESS,   t1 + 8);
    waitUntil(t1 + 12);
    t2 = edgeCount;
    applyStimulus(4'b0000, 1'b1);
    expectEvent(3, T_RELEASE, t2 + 7);
    waitUntil(t2 + 15);

    // Backpressure through a long hold and release.
    d0 = dropCount;
    t0 = edgeCount;
    applyStimulus(4'b0001, 1'b0);
    expectEvent(0, T_PRESS, t0 + 7);
    waitUntil(t0 + 60);
    applyStimulus(4'b0000, 1'b0);
    waitUntil(t0 + 72);
    checkOutput("bp_busy",  int'(busy),      1);
    checkOutput("bp_valid", int'(evt_valid), 1);
    applyStimulus(4'b0000, 1'b1);
    expectEvent(0, T_RELEASE, t0 + 73);
    waitUntil(t0 + 80);
    checkOutput("bp_drops", dropCount - d0, BP_DROPS);
    checkOutput("bp_idle",  int'(busy), 0);

    // Reset while an event is held; key 1 stays pressed through reset.
    d0 = dropCount;
    t0 = edgeCount;
    applyStimulus(4'b0010, 1'b0);
    expectEvent(1, T_PRESS, t0 + 7);
    waitUntil(t0 + 40);
    checkOutput("pre_rst_valid", int'(evt_valid), 1);
    checkOutput("pre_rst_busy",  int'(busy),      1);
    checkOutput("rst_drops", dropCount - d0, RST_DROPS);
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    applyStimulus(4'b0010, 1'b1);
    repeat (2) @(negedge clk);
    t1 = edgeCount;
    rst = 1'b0;
    expectEvent(1, T_PRESS, t1 + 7);
    waitUntil(t1 + 10);
    applyStimulus(4'b0000, 1'b1);
    expectEvent(1, T_RELEASE, t1 + 17);
    waitUntil(t1 + 30);

    checkOutput("sb_empty", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
